// File: rtl/imm_ext_pipe.sv
// Two-stage immediate extension pipeline with valid/ready handshakes on both sides.
// S1 holds the raw request; S2 holds the extended result that drives the outputs.
module imm_ext_pipe #(
  parameter int IMM_W  = 16,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic [2:0]        in_op,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_err
);

  localparam int EXT_W = DATA_W - IMM_W;

  logic              s1_valid;
  logic [IMM_W-1:0]  s1_imm;
  logic [2:0]        s1_op;
  logic [TAG_W-1:0]  s1_tag;
  logic              s2_valid;

  logic              s2_load;
  logic              accept;
  logic [DATA_W-1:0] sext;
  logic [DATA_W-1:0] ext_data;
  logic              ext_err;

  assign s2_load   = !s2_valid || out_ready;
  assign in_ready  = !rst && !flush && (!s1_valid || s2_load);
  assign accept    = in_valid && in_ready;
  assign out_valid = s2_valid;

  assign sext = {{EXT_W{s1_imm[IMM_W-1]}}, s1_imm};

  always_comb begin
    ext_data = '0;
    ext_err  = 1'b0;
    case (s1_op)
      3'd0: ext_data = '0;
      3'd1: ext_data = sext;
      3'd2: ext_data = {{EXT_W{1'b0}}, s1_imm};
      3'd3: ext_data = {s1_imm, {EXT_W{1'b0}}};
      // Shift of the full-width sign extension drops the top two bits naturally.
      3'd4: ext_data = sext << 2;
      3'd5: ext_data = {{EXT_W{1'b1}}, s1_imm};
      default: begin
        ext_data = '0;
        ext_err  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_imm   <= '0;
      s1_op    <= '0;
      s1_tag   <= '0;
      s2_valid <= 1'b0;
      out_data <= '0;
      out_tag  <= '0;
      out_err  <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (s2_load) begin
        s2_valid <= s1_valid;
        // Result registers only change when a real operation moves in.
        if (s1_valid) begin
          out_data <= ext_data;
          out_tag  <= s1_tag;
          out_err  <= ext_err;
        end
      end
      if (accept) begin
        s1_valid <= 1'b1;
        s1_imm   <= in_imm;
        s1_op    <= in_op;
        s1_tag   <= in_tag;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Randomized and directed checks of imm_ext_pipe against an arithmetic reference model.
module tb_imm_ext_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_imm;
  logic [2:0]  in_op;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_tag;
  logic        out_err;

  logic        p_flush;
  logic        p_in_valid;
  logic        p_in_ready;
  logic [11:0] p_in_imm;
  logic [2:0]  p_in_op;
  logic [3:0]  p_in_tag;
  logic        p_out_valid;
  logic        p_out_ready;
  logic [63:0] p_out_data;
  logic [3:0]  p_out_tag;
  logic        p_out_err;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  t;
    logic        e;
  } exp_t;
  exp_t expq[$];

  always #5 clk = ~clk;

  imm_ext_pipe #(.IMM_W(16), .DATA_W(32), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm), .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag), .out_err(out_err)
  );

  imm_ext_pipe #(.IMM_W(12), .DATA_W(64), .TAG_W(4)) dut64 (
    .clk(clk), .rst(rst), .flush(p_flush),
    .in_valid(p_in_valid), .in_ready(p_in_ready), .in_imm(p_in_imm), .in_op(p_in_op), .in_tag(p_in_tag),
    .out_valid(p_out_valid), .out_ready(p_out_ready), .out_data(p_out_data), .out_tag(p_out_tag), .out_err(p_out_err)
  );

  // Reference: {err, data} computed with signed/unsigned integer arithmetic.
  function automatic logic [32:0] ref_ext(input logic [15:0] imm, input logic [2:0] op);
    longint u = longint'(imm);
    longint sv = imm[15] ? u - 65536 : u;
    logic [63:0] r;
    case (op)
      3'd0: r = 64'd0;
      3'd1: r = sv;
      3'd2: r = u;
      3'd3: r = u * 65536;
      3'd4: r = sv * 4;
      3'd5: r = u + 64'hFFFF_FFFF_FFFF_0000;
      default: return {1'b1, 32'h0};
    endcase
    return {1'b0, r[31:0]};
  endfunction

  task automatic cycle(input logic v, input logic [15:0] imm, input logic [2:0] op,
                       input logic [3:0] tag, input logic ordy, input logic fl,
                       output logic rdy, output logic acc, output logic ov, output logic xfer,
                       output logic [31:0] d, output logic [3:0] t, output logic e);
    @(negedge clk);
    in_valid = v; in_imm = imm; in_op = op; in_tag = tag; out_ready = ordy; flush = fl;
    #1;
    rdy = in_ready; acc = v && in_ready; ov = out_valid;
    xfer = out_valid && ordy && !fl;
    d = out_data; t = out_tag; e = out_err;
  endtask

  task automatic test_reset();
    #2;
    vectors++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: in_ready=%b out_valid=%b out_err=%b, required 0 0 0", in_ready, out_valid, out_err);
    end
    vectors++;
    if (out_data !== 32'h0 || out_tag !== 4'h0) begin
      miscompares++;
      $display("FAIL reset_data: out_data=%h out_tag=%h, required 0 0", out_data, out_tag);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release_ready: in_ready=%b, required 1", in_ready);
    end
  endtask

  task automatic test_mode_table();
    logic [2:0]  ops[7]   = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd7};
    logic [31:0] exp_d[7] = '{32'hFFFF8000, 32'h00008000, 32'h80000000, 32'hFFFE0000,
                              32'hFFFF8000, 32'h0, 32'h0};
    logic rdy, acc, ov, xfer, e;
    logic [31:0] d;
    logic [3:0] t;
    int sent = 0, got = 0;
    for (int c = 0; c < 30 && got < 7; c++) begin
      cycle(sent < 7, 16'h8000, sent < 7 ? ops[sent] : 3'd0, 4'(sent), 1'b1, 1'b0,
            rdy, acc, ov, xfer, d, t, e);
      if (xfer) begin
        vectors++;
        if (d !== exp_d[got] || t !== 4'(got) || e !== (got == 6)) begin
          miscompares++;
          $display("FAIL mode_table[%0d]: data=%h tag=%h err=%b, required %h %h %b",
                   got, d, t, e, exp_d[got], 4'(got), got == 6);
        end
        got++;
      end
      if (acc) sent++;
    end
    vectors++;
    if (got != 7) begin
      miscompares++;
      $display("FAIL mode_table_timeout: results=%0d, required 7", got);
    end
  endtask

  task automatic test_edges();
    logic [15:0] imms[2]  = '{16'hFFFF, 16'h7FFF};
    logic [2:0]  ops[2]   = '{3'd4, 3'd1};
    logic [31:0] exp_d[2] = '{32'hFFFFFFFC, 32'h00007FFF};
    logic rdy, acc, ov, xfer, e;
    logic [31:0] d;
    logic [3:0] t;
    int sent = 0, got = 0;
    for (int c = 0; c < 20 && got < 2; c++) begin
      cycle(sent < 2, sent < 2 ? imms[sent] : 16'h0, sent < 2 ? ops[sent] : 3'd0, 4'(sent + 8),
            1'b1, 1'b0, rdy, acc, ov, xfer, d, t, e);
      if (xfer) begin
        vectors++;
        if (d !== exp_d[got] || e !== 1'b0 || t !== 4'(got + 8)) begin
          miscompares++;
          $display("FAIL edge[%0d]: data=%h err=%b tag=%h, required %h 0 %h", got, d, e, t, exp_d[got], 4'(got + 8));
        end
        got++;
      end
      if (acc) sent++;
    end
    vectors++;
    if (got != 2) begin
      miscompares++;
      $display("FAIL edge_timeout: results=%0d, required 2", got);
    end
  endtask

  task automatic test_back_to_back();
    logic rdy, acc, ov, xfer, e;
    logic [31:0] d;
    logic [3:0] t;
    logic [15:0] imm;
    logic [2:0] op;
    logic [32:0] r;
    exp_t x;
    int sent = 0, got = 0, first_acc = -1, last_x = -1;
    expq.delete();
    for (int c = 0; c < 30 && got < 8; c++) begin
      imm = 16'($urandom);
      op  = 3'($urandom_range(0, 5));
      cycle(sent < 8, imm, op, 4'(sent), 1'b1, 1'b0, rdy, acc, ov, xfer, d, t, e);
      if (xfer) begin
        x = expq.pop_front();
        vectors++;
        if (d !== x.d || t !== x.t || e !== x.e) begin
          miscompares++;
          $display("FAIL b2b_data[%0d]: data=%h tag=%h err=%b, required %h %h %b", got, d, t, e, x.d, x.t, x.e);
        end
        vectors++;
        if ((got == 0 && c != first_acc + 2) || (got != 0 && c != last_x + 1)) begin
          miscompares++;
          $display("FAIL b2b_timing[%0d]: cycle=%0d, required %0d", got, c,
                   got == 0 ? first_acc + 2 : last_x + 1);
        end
        last_x = c;
        got++;
      end
      if (acc) begin
        if (first_acc < 0) first_acc = c;
        r = ref_ext(imm, op);
        expq.push_back('{d: r[31:0], t: 4'(sent), e: r[32]});
        sent++;
      end
    end
    vectors++;
    if (got != 8) begin
      miscompares++;
      $display("FAIL b2b_timeout: results=%0d, required 8", got);
    end
  endtask

  task automatic test_backpressure();
    logic rdy, acc, ov, xfer, e;
    logic [31:0] d, held;
    logic [3:0] t, held_t;
    logic [15:0] imm;
    logic [2:0] op;
    logic [32:0] r;
    exp_t x;
    int sent = 0, got = 0, stall_acc = 0;
    expq.delete();
    held = 32'h0; held_t = 4'h0;
    for (int c = 0; c < 40 && got < 8; c++) begin
      imm = 16'($urandom);
      op  = 3'($urandom_range(0, 7));
      cycle(sent < 8, imm, op, 4'(sent), c >= 4, 1'b0, rdy, acc, ov, xfer, d, t, e);
      if (c < 4 && acc) stall_acc++;
      if (c == 2) begin
        held = d; held_t = t;
      end
      if (c == 2 || c == 3) begin
        vectors++;
        if (rdy !== 1'b0 || ov !== 1'b1) begin
          miscompares++;
          $display("FAIL bp_stall_flags[c%0d]: in_ready=%b out_valid=%b, required 0 1", c, rdy, ov);
        end
      end
      if (c == 3) begin
        vectors++;
        if (d !== held || t !== held_t) begin
          miscompares++;
          $display("FAIL bp_stable: data=%h tag=%h, required %h %h", d, t, held, held_t);
        end
      end
      if (xfer) begin
        x = expq.pop_front();
        vectors++;
        if (d !== x.d || t !== x.t || e !== x.e) begin
          miscompares++;
          $display("FAIL bp_data[%0d]: data=%h tag=%h err=%b, required %h %h %b", got, d, t, e, x.d, x.t, x.e);
        end
        got++;
      end
      if (acc) begin
        r = ref_ext(imm, op);
        expq.push_back('{d: r[31:0], t: 4'(sent), e: r[32]});
        sent++;
      end
    end
    vectors++;
    if (stall_acc != 2) begin
      miscompares++;
      $display("FAIL bp_accepts: accepts during stall=%0d, required 2", stall_acc);
    end
    vectors++;
    if (got != 8 || expq.size() != 0) begin
      miscompares++;
      $display("FAIL bp_count: results=%0d left=%0d, required 8 0", got, expq.size());
    end
  endtask

  task automatic test_flush();
    logic rdy, acc, ov, xfer, e;
    logic [31:0] d;
    logic [3:0] t;
    logic [32:0] r;
    int seen = 0;
    cycle(1'b1, 16'h1234, 3'd2, 4'hA, 1'b0, 1'b0, rdy, acc, ov, xfer, d, t, e);
    cycle(1'b1, 16'h5678, 3'd2, 4'hB, 1'b0, 1'b0, rdy, acc, ov, xfer, d, t, e);
    cycle(1'b1, 16'h9ABC, 3'd2, 4'hC, 1'b1, 1'b1, rdy, acc, ov, xfer, d, t, e);
    vectors++;
    if (rdy !== 1'b0 || ov !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_cycle: in_ready=%b out_valid=%b, required 0 1", rdy, ov);
    end
    for (int c = 0; c < 5; c++) begin
      cycle(1'b0, 16'h0, 3'd0, 4'h0, 1'b1, 1'b0, rdy, acc, ov, xfer, d, t, e);
      vectors++;
      if (ov !== 1'b0) begin
        miscompares++;
        $display("FAIL flush_drop[c%0d]: out_valid=%b tag=%h, required 0", c, ov, t);
      end
    end
    r = ref_ext(16'hF00D, 3'd5);
    for (int c = 0; c < 10 && seen == 0; c++) begin
      cycle(c == 0, 16'hF00D, 3'd5, 4'h5, 1'b1, 1'b0, rdy, acc, ov, xfer, d, t, e);
      if (xfer) begin
        seen = 1;
        vectors++;
        if (d !== r[31:0] || t !== 4'h5 || e !== 1'b0) begin
          miscompares++;
          $display("FAIL flush_recover: data=%h tag=%h err=%b, required %h 5 0", d, t, e, r[31:0]);
        end
      end
    end
    vectors++;
    if (seen == 0) begin
      miscompares++;
      $display("FAIL flush_recover_timeout: no result, required one");
    end
  endtask

  task automatic test_async_reset();
    logic rdy, acc, ov, xfer, e;
    logic [31:0] d;
    logic [3:0] t;
    cycle(1'b1, 16'h1111, 3'd1, 4'h3, 1'b0, 1'b0, rdy, acc, ov, xfer, d, t, e);
    cycle(1'b1, 16'h2222, 3'd1, 4'h4, 1'b0, 1'b0, rdy, acc, ov, xfer, d, t, e);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL arst_prefill: out_valid=%b, required 1", out_valid);
    end
    #1 rst = 1'b1;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_data !== 32'h0 || out_tag !== 4'h0) begin
      miscompares++;
      $display("FAIL arst_immediate: out_valid=%b in_ready=%b data=%h tag=%h, required 0 0 0 0",
               out_valid, in_ready, out_data, out_tag);
    end
    #1 rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      cycle(1'b0, 16'h0, 3'd0, 4'h0, 1'b1, 1'b0, rdy, acc, ov, xfer, d, t, e);
      vectors++;
      if (ov !== 1'b0 || rdy !== 1'b1) begin
        miscompares++;
        $display("FAIL arst_stale[c%0d]: out_valid=%b in_ready=%b, required 0 1", c, ov, rdy);
      end
    end
  endtask

  task automatic test_random();
    logic rdy, acc, ov, xfer, e, v, ordy, fl;
    logic [31:0] d;
    logic [3:0] t, tag;
    logic [15:0] imm;
    logic [2:0] op;
    logic [32:0] r;
    exp_t x;
    int n;
    expq.delete();
    for (int c = 0; c < 400; c++) begin
      v    = (c < 360) && ($urandom_range(0, 3) != 0);
      imm  = 16'($urandom);
      op   = 3'($urandom_range(0, 7));
      tag  = 4'($urandom);
      ordy = ($urandom_range(0, 3) != 0);
      fl   = (c < 360) && ($urandom_range(0, 29) == 0);
      n    = expq.size();
      cycle(v, imm, op, tag, ordy, fl, rdy, acc, ov, xfer, d, t, e);
      vectors++;
      if (rdy !== (!fl && (n < 2 || ordy))) begin
        miscompares++;
        $display("FAIL rand_ready[c%0d]: in_ready=%b, required %b", c, rdy, !fl && (n < 2 || ordy));
      end
      if (xfer) begin
        vectors++;
        if (expq.size() == 0) begin
          miscompares++;
          $display("FAIL rand_spurious[c%0d]: data=%h tag=%h, required no result", c, d, t);
        end else begin
          x = expq.pop_front();
          if (d !== x.d || t !== x.t || e !== x.e) begin
            miscompares++;
            $display("FAIL rand_data[c%0d]: data=%h tag=%h err=%b, required %h %h %b", c, d, t, e, x.d, x.t, x.e);
          end
        end
      end
      if (fl) expq.delete();
      if (acc) begin
        r = ref_ext(imm, op);
        expq.push_back('{d: r[31:0], t: tag, e: r[32]});
      end
    end
    vectors++;
    if (expq.size() != 0) begin
      miscompares++;
      $display("FAIL rand_leftover: %0d results never delivered, required 0", expq.size());
    end
  endtask

  task automatic test_param_sweep();
    logic [11:0] pi[3] = '{12'h800, 12'hABC, 12'h800};
    logic [2:0]  po[3] = '{3'd1, 3'd3, 3'd4};
    logic [63:0] pe[3] = '{64'hFFFFFFFFFFFFF800, 64'hABC0000000000000, 64'hFFFFFFFFFFFFE000};
    int seen;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      p_in_valid = 1'b1; p_in_imm = pi[i]; p_in_op = po[i]; p_in_tag = 4'(i);
      #1;
      vectors++;
      if (p_in_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL sweep_ready[%0d]: in_ready=%b, required 1", i, p_in_ready);
      end
      @(negedge clk);
      p_in_valid = 1'b0;
      #1;
      seen = 0;
      for (int k = 0; k < 6 && seen == 0; k++) begin
        if (p_out_valid) seen = 1;
        else begin
          @(negedge clk);
          #1;
        end
      end
      vectors++;
      if (seen == 0 || p_out_data !== pe[i] || p_out_tag !== 4'(i) || p_out_err !== 1'b0) begin
        miscompares++;
        $display("FAIL sweep_data[%0d]: valid=%0d data=%h tag=%h err=%b, required 1 %h %h 0",
                 i, seen, p_out_data, p_out_tag, p_out_err, pe[i], 4'(i));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_imm = '0; in_op = '0; in_tag = '0; out_ready = 1'b1;
    p_flush = 1'b0; p_in_valid = 1'b0; p_in_imm = '0; p_in_op = '0; p_in_tag = '0; p_out_ready = 1'b1;
    test_reset();
    test_mode_table();
    test_edges();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random();
    test_param_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
